// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit timing
// (12 MHz system clock, 115200 baud).
package uart_receiver_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 104;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_receiver_rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to the idle level (1) so leaving reset on an idle line is not a start bit.
module rx_synchronizer (
   input  logic clock,
   input  logic reset,
   input  logic rx,
   output logic rx_s
);

   logic meta_r;

   // Two-stage capture of rx into the clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_r <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         meta_r <= rx;
         rx_s   <= meta_r;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first. Bits are sampled near their centre: the start
// bit is confirmed half a bit after its falling edge, then every full bit.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       recv_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_s;
   rx_state_t        state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;

   rx_synchronizer u_sync (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .rx_s  (rx_s)
   );

   // Frame FSM with bit timing, shift register and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
         rx_byte      <= 8'h00;
         received     <= 1'b0;
         recv_error   <= 1'b0;
         is_receiving <= 1'b0;
      end else begin
         received   <= 1'b0;
         recv_error <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rx_s == 1'b0) begin
                  cnt_r        <= HALF_LOAD;
                  state_r      <= ST_START;
                  is_receiving <= 1'b1;
               end else begin
                  is_receiving <= 1'b0;
               end
            end
            ST_START: begin
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end else if (rx_s == 1'b1) begin
                  // Line went back high: treat as a glitch, not a frame.
                  state_r      <= ST_IDLE;
                  is_receiving <= 1'b0;
               end else begin
                  cnt_r     <= FULL_LOAD;
                  bit_idx_r <= 3'd0;
                  state_r   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end else begin
                  shift_r <= {rx_s, shift_r[7:1]};
                  cnt_r   <= FULL_LOAD;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end else if (rx_s == 1'b1) begin
                  rx_byte      <= shift_r;
                  received     <= 1'b1;
                  state_r      <= ST_IDLE;
                  is_receiving <= 1'b0;
               end else begin
                  // Framing error: keep the previous byte and wait for idle
                  // so a held-low line is not mistaken for a new start bit.
                  recv_error   <= 1'b1;
                  state_r      <= ST_WAIT_IDLE;
                  is_receiving <= 1'b0;
               end
            end
            ST_WAIT_IDLE: begin
               is_receiving <= 1'b0;
               if (rx_s == 1'b1) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_IDLE;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               cnt_r        <= '0;
               is_receiving <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with 4 clocks per bit.
module tb_uart_receiver;

   localparam int CPB = 4;

   logic       clock;
   logic       reset;
   logic       rx;
   logic       received;
   logic [7:0] rx_byte;
   logic       is_receiving;
   logic       recv_error;

   int checks = 0;
   int errors = 0;

   int         rcv_count = 0;
   int         err_count = 0;
   logic [7:0] rcv_log [0:31];
   logic       prev_received = 1'b0;
   logic       prev_error    = 1'b0;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx           (rx),
      .received     (received),
      .rx_byte      (rx_byte),
      .is_receiving (is_receiving),
      .recv_error   (recv_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Per-cycle monitor: pulse width, mutual exclusion, pulse logging.
   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (received && recv_error) begin
            errors++;
            $display("FAIL mutex: received=%b recv_error=%b, required not both 1", received, recv_error);
         end
         checks++;
         if ((received && prev_received) || (recv_error && prev_error)) begin
            errors++;
            $display("FAIL pulse_width: received=%b/%b recv_error=%b/%b (prev/now), required 1-cycle pulses",
                     prev_received, received, prev_error, recv_error);
         end
         if (received) begin
            if (rcv_count < 32) rcv_log[rcv_count] = rx_byte;
            rcv_count++;
         end
         if (recv_error) err_count++;
      end
      prev_received = received;
      prev_error    = recv_error;
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, output logic mid_busy);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(data[i]);
         if (i == 3) mid_busy = is_receiving;
      end
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (received !== 1'b0 || recv_error !== 1'b0 || is_receiving !== 1'b0 || rx_byte !== 8'h00) begin
         errors++;
         $display("FAIL %s: received=%b recv_error=%b is_receiving=%b rx_byte=%h, required 0 0 0 00",
                  name, received, recv_error, is_receiving, rx_byte);
      end
   endtask

   task automatic check_frame(input string name, input int rcv0, input int err0,
                              input int exp_rcv, input int exp_err, input logic [7:0] exp_byte);
      checks++;
      if ((rcv_count - rcv0) !== exp_rcv) begin
         errors++;
         $display("FAIL %s_rcv_count: got %0d required %0d", name, rcv_count - rcv0, exp_rcv);
      end
      checks++;
      if ((err_count - err0) !== exp_err) begin
         errors++;
         $display("FAIL %s_err_count: got %0d required %0d", name, err_count - err0, exp_err);
      end
      checks++;
      if (rx_byte !== exp_byte) begin
         errors++;
         $display("FAIL %s_rx_byte: got %h required %h", name, rx_byte, exp_byte);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clock);
      check_outputs_zero("reset_state");
      reset = 1'b0;
      idle_cycles(4);
      check_outputs_zero("after_reset_idle");
   endtask

   task automatic test_valid_frame();
      int   r0 = rcv_count;
      int   e0 = err_count;
      logic busy;
      send_frame(8'h55, 1'b1, busy);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL valid_busy: is_receiving=%b required 1", busy);
      end
      idle_cycles(8);
      check_frame("valid_55", r0, e0, 1, 0, 8'h55);
      checks++;
      if (rcv_log[r0] !== 8'h55) begin
         errors++;
         $display("FAIL valid_logged: got %h required 55", rcv_log[r0]);
      end
   endtask

   task automatic test_framing_error();
      int   r0 = rcv_count;
      int   e0 = err_count;
      logic busy;
      send_frame(8'hA3, 1'b0, busy);
      idle_cycles(10);
      check_frame("ferr_A3", r0, e0, 0, 1, 8'h55);
      r0 = rcv_count;
      e0 = err_count;
      send_frame(8'h3C, 1'b1, busy);
      idle_cycles(8);
      check_frame("after_ferr_3C", r0, e0, 1, 0, 8'h3C);
   endtask

   task automatic test_glitch();
      int   r0 = rcv_count;
      int   e0 = err_count;
      logic saw_busy = 1'b0;
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      for (int i = 1; i < CPB / 2 + 3; i++) begin
         @(negedge clock);
         if (is_receiving) saw_busy = 1'b1;
      end
      checks++;
      if (saw_busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_detected: saw is_receiving=%b required 1", saw_busy);
      end
      checks++;
      if (is_receiving !== 1'b0) begin
         errors++;
         $display("FAIL glitch_idle: is_receiving=%b required 0", is_receiving);
      end
      idle_cycles(8);
      check_frame("glitch", r0, e0, 0, 0, 8'h3C);
   endtask

   task automatic test_back_to_back();
      int   r0 = rcv_count;
      int   e0 = err_count;
      logic busy;
      send_frame(8'h01, 1'b1, busy);
      send_frame(8'hFF, 1'b1, busy);
      idle_cycles(8);
      check_frame("b2b", r0, e0, 2, 0, 8'hFF);
      checks++;
      if (rcv_log[r0] !== 8'h01 || rcv_log[r0 + 1] !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_order: got %h %h required 01 ff", rcv_log[r0], rcv_log[r0 + 1]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int   r0;
      int   e0;
      logic busy;
      logic [7:0] d = 8'h81;
      r0 = rcv_count;
      e0 = err_count;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      repeat (2) @(negedge clock);
      checks++;
      if (is_receiving !== 1'b1) begin
         errors++;
         $display("FAIL mid_frame_busy: is_receiving=%b required 1", is_receiving);
      end
      reset = 1'b1;
      #1;
      check_outputs_zero("reset_mid_frame_immediate");
      repeat (2) @(negedge clock);
      check_outputs_zero("reset_mid_frame_held");
      rx = 1'b1;
      reset = 1'b0;
      idle_cycles(3);
      send_frame(8'h42, 1'b1, busy);
      idle_cycles(8);
      check_frame("post_reset_42", r0, e0, 1, 0, 8'h42);
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      test_reset();
      test_valid_frame();
      test_framing_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
